// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the MAC array datapath.
// Used by mac_array and by the psum collector on its south edge.
package mac_pkg;

   localparam int PSUM_BW = 16;
   localparam int COL     = 8;
   localparam int DEPTH   = 16;

   function automatic logic [PSUM_BW-1:0] col_slice(
      input logic [PSUM_BW*COL-1:0] vec,
      input int                     c
   );
      return vec[PSUM_BW*c +: PSUM_BW];
   endfunction

endpackage

// File: rtl/col_fifo.sv
// Single-column first-word-fall-through FIFO with wrap-bit pointers.
// A write into a full FIFO is accepted only when a pop frees a slot.
module col_fifo
   import mac_pkg::*;
#(
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic [psum_bw-1:0] din,
   input  logic               rd,
   output logic [psum_bw-1:0] dout,
   output logic               empty,
   output logic               full,
   output logic               drop
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [psum_bw-1:0] mem_q [depth];
   logic               rd_ok, wr_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                & (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign rd_ok = rd & ~empty;
   // A pop in the same cycle frees the slot the write lands in.
   assign wr_ok = wr & (~full | rd_ok);
   assign drop  = wr & full & ~rd_ok;

   assign dout = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/psum_collector.sv
// De-skews column partial sums from the array south edge into
// row-aligned words handed downstream over valid/ready.
module psum_collector
   import mac_pkg::*;
#(
   parameter int psum_bw = PSUM_BW,
   parameter int col     = COL,
   parameter int depth   = DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in_s,
   input  logic [col-1:0]         valid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [psum_bw*col-1:0] out,
   output logic [col-1:0]         full,
   output logic                   overflow
);

   logic [col-1:0]         empty;
   logic [col-1:0]         drop;
   logic [psum_bw*col-1:0] head;
   logic                   pop;
   logic                   overflow_q, overflow_d;

   assign out_valid = ~|empty;
   // Every column pops together so rows never split.
   assign pop       = out_valid & out_ready;
   assign out       = out_valid ? head : '0;
   assign overflow  = overflow_q;

   for (genvar c = 0; c < col; c++) begin : g_col
      col_fifo #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .wr    (valid[c]),
         .din   (in_s[psum_bw*c +: psum_bw]),
         .rd    (pop),
         .dout  (head[psum_bw*c +: psum_bw]),
         .empty (empty[c]),
         .full  (full[c]),
         .drop  (drop[c])
      );
   end

   always_comb begin
      overflow_d = overflow_q | (|drop);
   end

   always_ff @(posedge clk) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

endmodule
